// File: rtl/heater_window_scheduler_pkg.sv
// Shared definitions for the time-proportional heater window scheduler.
package heater_window_scheduler_pkg;

  localparam int unsigned PID_W_DEFAULT  = 12;
  localparam int unsigned TIME_W_DEFAULT = 25;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RUN     = 2'd3
  } hws_state_t;

endpackage

// File: rtl/heater_window_scheduler.sv
// Per window: pulse CONV_EN with the held PID value, capture the clamped on-time,
// then drive HEATER_ON for that many cycles of a WINDOW_CYCLES-long window.
module heater_window_scheduler
  import heater_window_scheduler_pkg::*;
#(
  parameter int unsigned        PID_W         = PID_W_DEFAULT,
  parameter int unsigned        TIME_W        = TIME_W_DEFAULT,
  parameter logic [TIME_W-1:0]  WINDOW_CYCLES = TIME_W'(20000000),
  parameter logic [TIME_W-1:0]  MIN_ON        = TIME_W'(100000),
  parameter int unsigned        CONV_LATENCY  = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ENABLE,
  input  logic              FAULT,
  input  logic              PID_VALID,
  input  logic [PID_W-1:0]  PID_RESPONSE,
  output logic              CONV_EN,
  output logic [PID_W-1:0]  CONV_PID,
  input  logic [TIME_W-1:0] TIME_VALUE,
  output logic              HEATER_ON,
  output logic              WINDOW_DONE,
  output logic              FAULT_LATCHED
);

  localparam int unsigned       LAT_W    = (CONV_LATENCY > 1) ? $clog2(CONV_LATENCY) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(CONV_LATENCY - 1);
  localparam logic [TIME_W-1:0] CNT_LAST = WINDOW_CYCLES - TIME_W'(1);

  hws_state_t        state, state_nxt;
  logic [TIME_W-1:0] cnt, cnt_nxt;
  logic [TIME_W-1:0] on_time, on_time_nxt;
  logic [TIME_W-1:0] clamped;
  logic [LAT_W-1:0]  lat_cnt, lat_cnt_nxt;
  logic [PID_W-1:0]  pid_hold;
  logic              fault_nxt;
  logic              heater_nxt;
  logic              abort;
  logic              last_cycle;

  assign CONV_PID = pid_hold;

  always_comb begin
    if (TIME_VALUE < MIN_ON)
      clamped = '0;
    else if (TIME_VALUE >= WINDOW_CYCLES)
      clamped = WINDOW_CYCLES;
    else
      clamped = TIME_VALUE;
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    on_time_nxt = on_time;
    lat_cnt_nxt = lat_cnt;
    fault_nxt   = FAULT_LATCHED;
    abort       = FAULT || !ENABLE;
    last_cycle  = (cnt == CNT_LAST);

    if (FAULT)
      fault_nxt = 1'b1;
    else if (!ENABLE)
      fault_nxt = 1'b0;

    if (abort) begin
      state_nxt   = ST_IDLE;
      cnt_nxt     = '0;
      lat_cnt_nxt = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!FAULT_LATCHED)
            state_nxt = ST_CONVERT;
        end
        ST_CONVERT: begin
          state_nxt   = ST_WAIT;
          lat_cnt_nxt = '0;
        end
        ST_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            on_time_nxt = clamped;
            cnt_nxt     = '0;
            state_nxt   = ST_RUN;
          end else begin
            lat_cnt_nxt = lat_cnt + LAT_W'(1);
          end
        end
        ST_RUN: begin
          if (last_cycle) begin
            cnt_nxt   = '0;
            state_nxt = ST_CONVERT;
          end else begin
            cnt_nxt = cnt + TIME_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    // Heater register is loaded from next-state values so it lines up with cnt
    // and is already low in the cycle after the window ends.
    heater_nxt  = (state_nxt == ST_RUN) && (cnt_nxt < on_time_nxt);
    CONV_EN     = (state == ST_CONVERT);
    WINDOW_DONE = (state == ST_RUN) && last_cycle && !abort;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      on_time       <= '0;
      lat_cnt       <= '0;
      pid_hold      <= '0;
      HEATER_ON     <= 1'b0;
      FAULT_LATCHED <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      on_time       <= on_time_nxt;
      lat_cnt       <= lat_cnt_nxt;
      HEATER_ON     <= heater_nxt;
      FAULT_LATCHED <= fault_nxt;
      if (PID_VALID)
        pid_hold <= PID_RESPONSE;
    end
  end

endmodule

// File: tb/tb_heater_window_scheduler.sv
// Directed bench: WINDOW_CYCLES=20, MIN_ON=2, CONV_LATENCY=1, converter modelled
// as TIME_VALUE <= CONV_PID on the edge where CONV_EN is high.
module tb_heater_window_scheduler;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        ENABLE = 1'b0;
  logic        FAULT = 1'b0;
  logic        PID_VALID = 1'b0;
  logic [11:0] PID_RESPONSE = '0;
  logic        CONV_EN;
  logic [11:0] CONV_PID;
  logic [24:0] TIME_VALUE = '0;
  logic        HEATER_ON;
  logic        WINDOW_DONE;
  logic        FAULT_LATCHED;

  int n_checks = 0;
  int n_fail   = 0;

  heater_window_scheduler #(
    .PID_W        (12),
    .TIME_W       (25),
    .WINDOW_CYCLES(25'd20),
    .MIN_ON       (25'd2),
    .CONV_LATENCY (1)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .ENABLE       (ENABLE),
    .FAULT        (FAULT),
    .PID_VALID    (PID_VALID),
    .PID_RESPONSE (PID_RESPONSE),
    .CONV_EN      (CONV_EN),
    .CONV_PID     (CONV_PID),
    .TIME_VALUE   (TIME_VALUE),
    .HEATER_ON    (HEATER_ON),
    .WINDOW_DONE  (WINDOW_DONE),
    .FAULT_LATCHED(FAULT_LATCHED)
  );

  always #5 CLK = ~CLK;

  // Converter model: identity mapping, one cycle latency.
  always @(posedge CLK) begin
    if (!RST_N)
      TIME_VALUE <= '0;
    else if (CONV_EN)
      TIME_VALUE <= {13'd0, CONV_PID};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Starts at (or waits for) a CONVERT cycle and follows one full 22-cycle period.
  task automatic run_window(input string tag, input int exp_on, input int inject_tick,
                            input logic [11:0] new_pid);
    int waited   = 0;
    int on_cnt   = 0;
    int pat_err  = 0;
    int done_cnt = 0;
    int done_pos = 0;
    int en_cnt   = 0;
    while (!CONV_EN && waited < 60) begin
      tick();
      waited++;
    end
    if (!CONV_EN) begin
      check({tag, "_start_timeout"}, 32'd0, 32'd1);
      return;
    end
    check({tag, "_heater_in_convert"}, HEATER_ON, 32'd0);
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == 22) begin
        check({tag, "_period_conv_en"}, CONV_EN, 32'd1);
        check({tag, "_heater_after_window"}, HEATER_ON, 32'd0);
      end else begin
        if (HEATER_ON) on_cnt++;
        if (HEATER_ON !== ((i >= 2) && (i - 2 < exp_on))) pat_err++;
        if (WINDOW_DONE) begin
          done_cnt++;
          done_pos = i;
        end
        if (CONV_EN) en_cnt++;
      end
      if (inject_tick > 0 && i == inject_tick) begin
        PID_VALID    = 1'b1;
        PID_RESPONSE = new_pid;
      end
      if (inject_tick > 0 && i == inject_tick + 1) begin
        PID_VALID    = 1'b0;
        PID_RESPONSE = '0;
        check({tag, "_conv_pid_updated"}, CONV_PID, new_pid);
      end
    end
    check({tag, "_on_cycles"}, on_cnt, exp_on);
    check({tag, "_on_pattern_errs"}, pat_err, 32'd0);
    check({tag, "_done_count"}, done_cnt, 32'd1);
    check({tag, "_done_position"}, done_pos, 32'd21);
    check({tag, "_extra_conv_en"}, en_cnt, 32'd0);
  endtask

  initial begin
    int any_out;
    int cnt_a;
    int cnt_b;
    int waited;

    // 1: reset and idle
    any_out = 0;
    cnt_a   = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (HEATER_ON || WINDOW_DONE || FAULT_LATCHED) any_out++;
      if (CONV_EN) cnt_a++;
    end
    check("reset_outputs", any_out, 32'd0);
    check("reset_conv_en", cnt_a, 32'd0);
    check("reset_conv_pid", CONV_PID, 32'd0);
    RST_N = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (CONV_EN || HEATER_ON || WINDOW_DONE) cnt_a++;
    end
    check("idle_disabled_quiet", cnt_a, 32'd0);

    // 2: first window with on-time 8
    PID_VALID    = 1'b1;
    PID_RESPONSE = 12'd8;
    tick();
    PID_VALID    = 1'b0;
    PID_RESPONSE = '0;
    check("pid_hold_8", CONV_PID, 32'd8);
    ENABLE = 1'b1;

    // 3/4: on-time changes always staged mid-RUN, applied to the following window
    run_window("w8", 8, 5, 12'd1);
    run_window("w_below_min", 0, 5, 12'd25);
    run_window("w_over_full", 20, 5, 12'd2);
    run_window("w_at_min", 2, 5, 12'd19);
    run_window("w19", 19, 5, 12'd20);
    run_window("w_eq_window", 20, 0, 12'd0);

    // 5: fault at RUN cnt=3 (now in CONVERT of a full-on window)
    for (int i = 0; i < 5; i++) tick();
    check("fault_pre_heater", HEATER_ON, 32'd1);
    FAULT = 1'b1;
    tick();
    FAULT = 1'b0;
    check("fault_heater_off", HEATER_ON, 32'd0);
    check("fault_latched", FAULT_LATCHED, 32'd1);
    check("fault_no_done", WINDOW_DONE, 32'd0);
    cnt_a = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (CONV_EN || HEATER_ON) cnt_a++;
    end
    check("fault_no_restart", cnt_a, 32'd0);
    check("fault_still_latched", FAULT_LATCHED, 32'd1);
    ENABLE = 1'b0;
    FAULT  = 1'b1;
    tick();
    check("fault_beats_enable_low", FAULT_LATCHED, 32'd1);
    FAULT = 1'b0;
    tick();
    check("fault_cleared", FAULT_LATCHED, 32'd0);
    ENABLE = 1'b1;
    run_window("rearm", 20, 5, 12'd8);
    run_window("rearm_next", 8, 0, 12'd0);

    // 6: ENABLE low at cnt=5
    for (int i = 0; i < 7; i++) tick();
    check("disable_pre_heater", HEATER_ON, 32'd1);
    ENABLE = 1'b0;
    tick();
    check("disable_heater_off", HEATER_ON, 32'd0);
    check("disable_no_done", WINDOW_DONE, 32'd0);
    cnt_a = 0;
    cnt_b = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (WINDOW_DONE) cnt_a++;
      if (CONV_EN || HEATER_ON) cnt_b++;
    end
    check("disable_done_count", cnt_a, 32'd0);
    check("disable_quiet", cnt_b, 32'd0);

    // reset mid-RUN
    ENABLE = 1'b1;
    waited = 0;
    while (!CONV_EN && waited < 10) begin
      tick();
      waited++;
    end
    check("restart_conv_en", CONV_EN, 32'd1);
    for (int i = 0; i < 8; i++) tick();
    check("rst_pre_heater", HEATER_ON, 32'd1);
    RST_N = 1'b0;
    tick();
    check("rst_heater", HEATER_ON, 32'd0);
    check("rst_conv_pid", CONV_PID, 32'd0);
    check("rst_conv_en", CONV_EN, 32'd0);
    check("rst_done", WINDOW_DONE, 32'd0);
    check("rst_fault", FAULT_LATCHED, 32'd0);
    ENABLE = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
